// File: rtl/alu_pkg.sv
// Shared ALU opcodes and datapath width for the execute-stage ALU and its users.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_t;

    localparam int ALU_W = 64;

endpackage

// File: rtl/alu.sv
// Combinational execute-stage ALU: add/sub/and/xor with signed overflow.
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         of
);

    always_comb begin
        y  = '0;
        of = 1'b0;
        case (alu_op_t'(op))
            ALU_ADD: begin
                y  = a + b;
                of = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                y  = a - b;
                of = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            ALU_AND: y = a & b;
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    logic last;

    // On a tie the requester opposite the last grant wins.
    assign grant[0] = en && valid[0] && (!valid[1] || last);
    assign grant[1] = en && valid[1] && (!valid[0] || !last);

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (|grant)
            last <= grant[1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters; results land in a
// one-entry response buffer tagged with the issuing requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_of,
    output logic         rsp_zf,
    output logic         rsp_sf
);

    logic         slot_free;
    logic [1:0]   grant;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic         alu_of;

    assign slot_free = !rsp_valid || rsp_ready;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .en    (slot_free && !rst),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Requester 0 drives the ALU whenever requester 1 does not hold the grant.
    assign alu_op = grant[1] ? req1_op : req0_op;
    assign alu_a  = grant[1] ? req1_a  : req0_a;
    assign alu_b  = grant[1] ? req1_b  : req0_b;

    alu #(.W(W)) u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y),
        .of (alu_of)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_of    <= 1'b0;
        end else if (|grant) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant[1];
            rsp_data  <= alu_y;
            rsp_of    <= alu_of;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_zf = (rsp_data == '0);
    assign rsp_sf = rsp_data[W-1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b1, req1_valid = 1'b1;
    logic [1:0]  req0_op = 2'd0, req1_op = 2'd0;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_of, rsp_zf, rsp_sf;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_of(rsp_of), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference ALU: overflow means the true signed result does not fit in 64 bits.
    function automatic void ref_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] y, output logic o);
        logic signed [64:0] wide;
        wide = '0;
        o = 1'b0;
        case (op)
            2'd0: begin wide = $signed({a[63], a}) + $signed({b[63], b}); y = wide[63:0]; o = wide[64] != wide[63]; end
            2'd1: begin wide = $signed({a[63], a}) - $signed({b[63], b}); y = wide[63:0]; o = wide[64] != wide[63]; end
            2'd2: y = a & b;
            default: y = a ^ b;
        endcase
    endfunction

    // Model state: contents of the response slot and who was served last.
    logic        m_v = 1'b0, m_id = 1'b0, m_of = 1'b0, m_last = 1'b1;
    logic [63:0] m_data = '0;

    always @(negedge clk) begin
        int          win;
        logic        free;
        logic [63:0] y;
        logic        o;
        free = !m_v || rsp_ready;
        win = -1;
        if (!rst && free) begin
            if (req0_valid && req1_valid) win = m_last ? 0 : 1;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        chk("m_req0_ready", 64'(req0_ready), 64'(win == 0));
        chk("m_req1_ready", 64'(req1_ready), 64'(win == 1));
        chk("m_rsp_valid", 64'(rsp_valid), 64'(m_v));
        if (m_v) begin
            chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
            chk("m_rsp_data", rsp_data, m_data);
            chk("m_rsp_of", 64'(rsp_of), 64'(m_of));
            chk("m_rsp_zf", 64'(rsp_zf), 64'(m_data == 64'd0));
            chk("m_rsp_sf", 64'(rsp_sf), 64'(m_data[63]));
        end
        if (rst) begin
            m_v = 1'b0; m_id = 1'b0; m_data = '0; m_of = 1'b0; m_last = 1'b1;
        end else if (win == 0) begin
            ref_alu(req0_op, req0_a, req0_b, y, o);
            m_v = 1'b1; m_id = 1'b0; m_data = y; m_of = o; m_last = 1'b0;
        end else if (win == 1) begin
            ref_alu(req1_op, req1_a, req1_b, y, o);
            m_v = 1'b1; m_id = 1'b1; m_data = y; m_of = o; m_last = 1'b1;
        end else if (rsp_ready) begin
            m_v = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return MAXP;
            3: return MINN;
            4: return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        // Reset with both requesters asking: nothing may be granted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_req0_ready", 64'(req0_ready), 64'd0);
            chk("rst_req1_ready", 64'(req1_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_zf", 64'(rsp_zf), 64'd1);
        end
        cyc();
        rst = 1'b0; rsp_ready = 1'b1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = MAXP; req0_b = MAXP;
        @(negedge clk);
        chk("ovf_req0_ready", 64'(req0_ready), 64'd1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'd0; req1_a = MINN; req1_b = MINN;
        @(negedge clk);
        chk("ovf_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("ovf_of", 64'(rsp_of), 64'd1);
        chk("ovf_sf", 64'(rsp_sf), 64'd1);
        chk("ovf_id", 64'(rsp_id), 64'd0);
        cyc();
        req1_op = 2'd1; req1_a = MAXP; req1_b = MINN;
        @(negedge clk);
        chk("addneg_data", rsp_data, 64'd0);
        chk("addneg_of", 64'(rsp_of), 64'd1);
        chk("addneg_zf", 64'(rsp_zf), 64'd1);
        chk("addneg_id", 64'(rsp_id), 64'd1);
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("sub_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub_of", 64'(rsp_of), 64'd1);
        cyc();
        // Continuous tie: grants must alternate starting with requester 0.
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd5; req0_b = 64'd6;
        req1_valid = 1'b1; req1_op = 2'd2; req1_a = 64'hFF; req1_b = 64'h0F;
        for (int k = 0; k < 6; k++) begin
            cyc();
            @(negedge clk);
            chk("fair_valid", 64'(rsp_valid), 64'd1);
            chk("fair_id", 64'(rsp_id), 64'(k % 2));
            chk("fair_data", rsp_data, (k % 2 == 0) ? 64'd11 : 64'h0F);
        end
        cyc();
        req1_valid = 1'b0;
        req0_op = 2'd3; req0_a = 64'hF0; req0_b = 64'hFF;
        cyc();
        rsp_ready = 1'b0;
        req0_op = 2'd2; req0_a = 64'hF0; req0_b = 64'h3C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_data", rsp_data, 64'h0F);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_req0_ready", 64'(req0_ready), 64'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req0_ready), 64'd1);
        chk("bp_release_data", rsp_data, 64'h0F);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_data", rsp_data, 64'h30);
        cyc();
        // Leave requester 0 as last grant, then reset with a result held.
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd1; req0_b = 64'd2;
        rsp_ready = 1'b0;
        cyc();
        req0_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_held", 64'(rsp_valid), 64'd1);
        chk("mid_rst_ready", 64'(req0_ready), 64'd0);
        cyc();
        rst = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_tie0", 64'(req0_ready), 64'd1);
        chk("mid_rst_tie1", 64'(req1_ready), 64'd0);
        cyc();
        @(negedge clk);
        chk("mid_rst_id", 64'(rsp_id), 64'd0);
        // Randomized traffic, backpressure and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst        = ($urandom_range(0, 63) == 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 2) != 0;
            req0_op = 2'($urandom_range(0, 3)); req0_a = pick(); req0_b = pick();
            req1_op = 2'($urandom_range(0, 3)); req1_a = pick(); req1_b = pick();
        end
        cyc();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 64-bit execute-stage ALU between two requesters, for example the Y86 execute stage and an address-generation/stack-pointer port. The block accepts operations through a valid/ready handshake and arbitrates round-robin. It drives the combinational ALU and captures each result in a one-entry registered response buffer, tagged with the winning requester's ID. Sustained throughput is one operation per cycle.

## Interface
- `W`, default 64: operand/result width.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `req0_valid`, input, 1: requester 0 has an operation.
- `req0_op`, input, 2: ALU control. 00 add, 01 sub (a−b), 10 and, 11 xor.
- `req0_a`, `req0_b`, input, W: signed operands.
- `req0_ready`, output, 1: requester 0 accepted this cycle.
- `req1_valid`, `req1_op`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0.
- `rsp_valid`, output, 1: response buffer holds a result.
- `rsp_ready`, input, 1: consumer takes the result.
- `rsp_id`, output, 1: requester that issued the result.
- `rsp_data`, output, W: ALU result.
- `rsp_of`, output, 1: signed overflow from the ALU.
- `rsp_zf`, output, 1: `rsp_data == 0`.
- `rsp_sf`, output, 1: `rsp_data[W-1]`.

## Operation
- Slot free condition: `slot_free = !rsp_valid || rsp_ready`.
- Arbitration happens only when `slot_free` is 1.
  - Exactly one valid requester: it wins.
  - Both valid: the requester opposite `last_grant` wins.
  - Neither valid: no grant.
- `reqN_ready = slot_free && (winner == N)`. It is combinational and asserted for at most one requester per cycle.
- `last_grant` updates only on an accepted transfer. Its reset value is 1, so requester 0 wins the first tie.
- ALU mux: the winner's `op`, `a` and `b` drive the ALU. When there is no grant, the mux holds requester 0's inputs; the ALU output is ignored in that case.
- On accept, the buffer loads `rsp_data`, `rsp_of` and `rsp_id`, and sets `rsp_valid = 1`.
- `rsp_zf` and `rsp_sf` are derived from the buffered `rsp_data`, not from the ALU output.
- `rsp_of` is 1 only for add/sub signed overflow, and is always 0 for and/xor. This matches the ALU contract.
- Arithmetic wraps modulo 2^W. There is no saturation.
- Response states:
  - EMPTY: on accept, go to FULL.
  - FULL with `rsp_ready = 0`: hold all `rsp_*` stable and keep both `reqN_ready` low.
  - FULL with `rsp_ready = 1` and an accept in the same cycle: the buffer reloads and stays FULL (back-to-back).
  - FULL with `rsp_ready = 1` and no accept: go to EMPTY.
- A requester may drop `valid` without a transfer. There is no stickiness requirement on requesters.

## Timing
- Reset values: `rsp_valid = 0`, `rsp_id = 0`, `rsp_data = 0`, `rsp_of = 0`, `last_grant = 1`. As a result, `rsp_zf = 1` and `rsp_sf = 0`.
- During the reset cycle, `req0_ready` and `req1_ready` are forced to 0.
- Latency: an operation accepted on edge N gives `rsp_valid = 1` with the result in the cycle after edge N. The latency is 1 cycle.
- Throughput: one result per cycle while `rsp_ready` is held high and requests are present. When both requesters are held valid, grants alternate 0,1,0,1.
- Reset asserted mid-stream: any buffered response is discarded. No `reqN_ready` is asserted in the reset cycle. `last_grant` returns to 1.
- There is no combinational path from `rsp_ready` to `rsp_*`. Paths from `rsp_ready` to `reqN_ready` are allowed.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_ADD = 2'b00`, `ALU_SUB = 2'b01`, `ALU_AND = 2'b10`, `ALU_XOR = 2'b11`.
  - Width constant `ALU_W = 64`.
- Sub-modules:
  - The existing `alu` is instantiated unchanged.
  - `rr_arb2` is a natural sub-module: 2-way round-robin with pointer, inputs `valid[1:0]` and `en`, outputs `grant[1:0]`.
- The response buffer and flag derivation stay in the top level.

## Test plan
- **Reset state:** assert `rst` for 2 cycles with both requesters valid. Expect `req*_ready = 0`, `rsp_valid = 0` and `rsp_zf = 1` throughout.
- **Overflow:** req0 add, a = b = 0x7FFF_FFFF_FFFF_FFFF. One cycle later expect `rsp_data = 0xFFFF_FFFF_FFFF_FFFE`, `rsp_of = 1`, `rsp_sf = 1`, `rsp_id = 0`.
- **Flags and id:** req1 add, a = b = 0x8000_0000_0000_0000. Expect `rsp_data = 0`, `rsp_of = 1`, `rsp_zf = 1`, `rsp_id = 1`. Then req1 sub with a = 0x7FFF_FFFF_FFFF_FFFF, b = 0x8000_0000_0000_0000. Expect `rsp_data = 0xFFFF_FFFF_FFFF_FFFF` and `rsp_of = 1`.
- **Fairness:** both requesters valid continuously, `rsp_ready = 1`, 6 cycles. Expect `rsp_id` sequence 0,1,0,1,0,1 with one result per cycle.
- **Backpressure:** `rsp_ready = 0` for 3 cycles with a result held (xor, a = 0xF0, b = 0xFF, giving 0x0F). Expect `rsp_*` stable and `req*_ready = 0`. Then `rsp_ready = 1` with a pending and op: expect it accepted the same cycle, with the next result the following cycle.
- **Reset mid-operation:** `rsp_valid = 1` and `rsp_ready = 0`, then pulse `rst` for one cycle. Expect `rsp_valid = 0` after the edge, and the next tie granted to requester 0.
